spi_flash_responder: RTL and testbench

- SPI slave emulating a serial NOR flash: decodes the 03h READ command on sck/ce_n/mosi and streams bytes from a byte-wide backing memory on miso.
- Bench and FPGA counterpart of the 03h line-fill flash reader; serves 16-byte cache-line fills or any burst length.
- SPI pins are oversampled in the system clock domain; no logic is clocked by sck.

---
 rtl/spi_flash_responder.sv | 190 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder: serves 03h READ bursts from a byte-wide memory, all logic on clk.
// Define SPI_FLASH_RESPONDER_FAST_READ_EN to also accept 0Bh FAST READ (8 dummy clocks).
module spi_flash_responder #(
  parameter int ADDR_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ce_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  output logic                  busy,
  output logic                  cmd_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, ce_sync_q, mosi_sync_q;
  logic                   sck_d_q, ce_d_q;
  logic                   sck_s, ce_s, mosi_s, rise, fall, ce_fall;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [22:0]            sh_in_q, sh_in_d;
  logic [7:0]             sh_out_q, sh_out_d, nxt_q, nxt_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d, mem_addr_q, mem_addr_d;
  logic                   first_q, first_d, pend_q, pend_d, fast_q, fast_d;
  logic                   miso_q, miso_d, mem_rd_q, mem_rd_d, cmd_err_q, cmd_err_d;
  logic [7:0]             opcode;
  logic [23:0]            addr_rx;
  logic                   op_fast;

  assign sck_s   = sck_sync_q[SYNC_STAGES-1];
  assign ce_s    = ce_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_d_q;
  assign fall    = ~sck_s & sck_d_q;
  assign ce_fall = ~ce_s & ce_d_q;
  assign opcode  = {sh_in_q[6:0], mosi_s};
  assign addr_rx = {sh_in_q, mosi_s};

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  assign op_fast = (opcode == 8'h0B);
`else
  assign op_fast = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ce_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_d_q     <= 1'b0;
      ce_d_q      <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], ce_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_d_q     <= sck_s;
      ce_d_q      <= ce_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh_in_q    <= '0;
      sh_out_q   <= '0;
      nxt_q      <= '0;
      rd_ptr_q   <= '0;
      mem_addr_q <= '0;
      first_q    <= 1'b0;
      pend_q     <= 1'b0;
      fast_q     <= 1'b0;
      miso_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_in_q    <= sh_in_d;
      sh_out_q   <= sh_out_d;
      nxt_q      <= nxt_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_addr_q <= mem_addr_d;
      first_q    <= first_d;
      pend_q     <= pend_d;
      fast_q     <= fast_d;
      miso_q     <= miso_d;
      mem_rd_q   <= mem_rd_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_in_d    = sh_in_q;
    sh_out_d   = sh_out_q;
    nxt_d      = nxt_q;
    rd_ptr_d   = rd_ptr_q;
    mem_addr_d = mem_addr_q;
    first_d    = first_q;
    pend_d     = mem_rd_q;
    fast_d     = fast_q;
    miso_d     = 1'b0;
    mem_rd_d   = 1'b0;
    cmd_err_d  = 1'b0;
    // Read data lands one clk after the strobe: the first byte goes straight
    // to the output shifter, prefetched bytes wait until the current LSB is out.
    if (pend_q) begin
      if (first_q) begin
        sh_out_d = mem_data;
        first_d  = 1'b0;
      end else begin
        nxt_d = mem_data;
      end
    end
    if (ce_s) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      pend_d    = 1'b0;
      first_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ce_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end
        CMD: if (rise) begin
          sh_in_d   = {sh_in_q[21:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            fast_d    = op_fast;
            if (opcode == 8'h03 || op_fast) state_d = ADDR;
            else begin
              cmd_err_d = 1'b1;
              state_d   = IGNORE;
            end
          end
        end
        ADDR: if (rise) begin
          sh_in_d   = {sh_in_q[21:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d  = '0;
            rd_ptr_d   = addr_rx[ADDR_WIDTH-1:0];
            mem_addr_d = addr_rx[ADDR_WIDTH-1:0];
            mem_rd_d   = 1'b1;
            first_d    = 1'b1;
            state_d    = fast_q ? DUMMY : DATA;
          end
        end
        DUMMY: if (rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
        DATA: begin
          miso_d = miso_q;
          if (fall) begin
            miso_d    = sh_out_q[7];
            sh_out_d  = (bit_cnt_q[2:0] == 3'd7) ? nxt_q : {sh_out_q[6:0], 1'b0};
            bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
            if (bit_cnt_q[2:0] == 3'd0) begin
              rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
              mem_addr_d = rd_ptr_q + ADDR_WIDTH'(1);
              mem_rd_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign miso     = miso_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign cmd_err  = cmd_err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench: 24-bit and 8-bit address instances share the SPI pins; memory holds mem[i]=i[7:0].
module tb_spi_flash_responder;
  logic       clk = 1'b0, rst = 1'b1, sck = 1'b0, ce_n = 1'b1, mosi = 1'b0;
  logic       miso, mem_rd, busy, cmd_err;
  logic [23:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic       miso8, mem_rd8, busy8, cmd_err8;
  logic [7:0] mem_addr8;
  logic [7:0] mem_data8 = 8'h00;
  int         total = 0, bad = 0;
  int         rd_cnt = 0, err_cnt = 0, miso_hi = 0, busy_lo = 0;
  bit         in_tx = 1'b0;

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_WIDTH(24), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_n), .mosi(mosi), .miso(miso),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .cmd_err(cmd_err));

  spi_flash_responder #(.ADDR_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_n), .mosi(mosi), .miso(miso8),
    .mem_rd(mem_rd8), .mem_addr(mem_addr8), .mem_data(mem_data8), .busy(busy8), .cmd_err(cmd_err8));

  always @(posedge clk) begin
    if (mem_rd)  mem_data  <= mem_addr[7:0];
    if (mem_rd8) mem_data8 <= mem_addr8;
    if (mem_rd)  rd_cnt  <= rd_cnt + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
    if (miso)    miso_hi <= miso_hi + 1;
    if (in_tx && !busy) busy_lo <= busy_lo + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sck period, master samples miso just before the rise; optionally leave sck high.
  task automatic sbit(input logic b, input bit hold_high, output logic r, output logic r8);
    mosi = b;
    repeat (4) @(negedge clk);
    r = miso; r8 = miso8;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    if (!hold_high) sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, input bit last, output logic [7:0] rx, output logic [7:0] rx8);
    logic r, r8;
    for (int i = 7; i >= 0; i--) begin
      sbit(tx[i], last && (i == 0), r, r8);
      rx  = {rx[6:0], r};
      rx8 = {rx8[6:0], r8};
    end
  endtask

  task automatic start_tx();
    ce_n = 1'b0;
    repeat (4) @(negedge clk);
    in_tx = 1'b1;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] r, r8;
    xfer(op, 1'b0, r, r8);
    xfer(a[23:16], 1'b0, r, r8);
    xfer(a[15:8], 1'b0, r, r8);
    xfer(a[7:0], 1'b0, r, r8);
  endtask

  // Two synchronizer stages plus the state register: busy drops on the third clk.
  task automatic finish_tx(input string tag);
    in_tx = 1'b0;
    ce_n  = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_busy_sync"}, busy, 1);
    @(negedge clk);
    check({tag, "_busy_idle"}, busy, 0);
    sck = 1'b0; mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r, r8, e, bits;
    logic       b, b8;
    int         s_rd, s_err, s_hi, s_lo;

    repeat (3) @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_err", cmd_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 16-byte line fill from 000010h; one fetch on the last address rise plus one per MSB fall
    s_rd = rd_cnt; s_lo = busy_lo;
    start_tx();
    send_hdr(8'h03, 24'h000010);
    for (int i = 0; i < 16; i++) begin
      xfer(8'h00, i == 15, r, r8);
      check($sformatf("fill_byte%0d", i), r, 8'h10 + i);
    end
    finish_tx("fill");
    check("fill_mem_rd_cnt", rd_cnt - s_rd, 17);
    check("fill_busy_gap", busy_lo - s_lo, 0);

    // address truncation / wrap on the 8-bit instance
    start_tx();
    send_hdr(8'h03, 24'h1234FE);
    e = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, i == 3, r, r8);
      check($sformatf("wrap8_byte%0d", i), r8, e);
      check($sformatf("wrap24_byte%0d", i), r, e);
      e = e + 8'd1;
    end
    finish_tx("wrap");
    check("wrap8_mem_addr", mem_addr8, 8'h02);
    check("wrap24_mem_addr", mem_addr, 24'h123502);

    // unsupported opcode
    s_rd = rd_cnt; s_err = err_cnt; s_hi = miso_hi; s_lo = busy_lo;
    start_tx();
    xfer(8'h9F, 1'b0, r, r8);
    for (int i = 0; i < 5; i++) xfer(8'hFF, i == 4, r, r8);
    finish_tx("ign");
    check("ign_cmd_err_cnt", err_cnt - s_err, 1);
    check("ign_miso_hi", miso_hi - s_hi, 0);
    check("ign_mem_rd_cnt", rd_cnt - s_rd, 0);
    check("ign_busy_gap", busy_lo - s_lo, 0);
    start_tx();
    send_hdr(8'h03, 24'h000005);
    xfer(8'h00, 1'b1, r, r8);
    check("after_ign_byte", r, 8'h05);
    finish_tx("after_ign");

    // abort three bits into the second byte
    start_tx();
    send_hdr(8'h03, 24'h000040);
    xfer(8'h00, 1'b0, r, r8);
    check("abort_byte0", r, 8'h40);
    bits = 8'h00;
    for (int i = 0; i < 3; i++) begin
      sbit(1'b0, 1'b0, b, b8);
      bits = {bits[6:0], b};
    end
    check("abort_partial_bits", bits, 8'h02);
    finish_tx("abort");
    start_tx();
    send_hdr(8'h03, 24'h000000);
    xfer(8'h00, 1'b1, r, r8);
    check("after_abort_byte", r, 8'h00);
    finish_tx("after_abort");

    // reset in the middle of a burst, just after the MSB of 81h is driven
    start_tx();
    send_hdr(8'h03, 24'h000080);
    xfer(8'h00, 1'b0, r, r8);
    check("rstmid_byte0", r, 8'h80);
    repeat (3) @(negedge clk);
    check("rstmid_pre_miso", miso, 1);
    in_tx = 1'b0;
    rst = 1'b1;
    #1;
    check("rstmid_miso", miso, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_mem_rd", mem_rd, 0);
    ce_n = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    start_tx();
    send_hdr(8'h03, 24'h000033);
    xfer(8'h00, 1'b1, r, r8);
    check("after_rst_byte", r, 8'h33);
    finish_tx("after_rst");

    // 0Bh fast read: header, one dummy byte, two data bytes
    s_err = err_cnt; s_hi = miso_hi;
    start_tx();
    send_hdr(8'h0B, 24'h000020);
    xfer(8'h00, 1'b0, r, r8);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    check("fast_dummy_miso", r, 8'h00);
    xfer(8'h00, 1'b0, r, r8);
    check("fast_byte0", r, 8'h20);
    xfer(8'h00, 1'b1, r, r8);
    check("fast_byte1", r, 8'h21);
    finish_tx("fast");
    check("fast_cmd_err_cnt", err_cnt - s_err, 0);
`else
    xfer(8'h00, 1'b0, r, r8);
    check("fast_off_byte0", r, 8'h00);
    xfer(8'h00, 1'b1, r, r8);
    check("fast_off_byte1", r, 8'h00);
    finish_tx("fast_off");
    check("fast_off_cmd_err_cnt", err_cnt - s_err, 1);
    check("fast_off_miso_hi", miso_hi - s_hi, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
